pulse_seq_ctrl: RTL and testbench

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_ctrl_pkg.sv | 35 +++
 rtl/pulse_desc_table.sv | 40 ++++
 rtl/pulse_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_ctrl_pkg.sv
// Shared types and defaults for the pulse-train sequencer: one-hot state
// encoding, the train descriptor layout and the descriptor reset value.
package pulse_seq_ctrl_pkg;

    localparam int NUM_ENTRIES_DEF = 8;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int START_CYC_DEF   = 4;

    typedef enum logic [7:0] {
        ST_IDLE   = 8'b0000_0001,
        ST_LOAD   = 8'b0000_0010,
        ST_SETTLE = 8'b0000_0100,
        ST_START  = 8'b0000_1000,
        ST_WAIT   = 8'b0001_0000,
        ST_NEXT   = 8'b0010_0000,
        ST_DRAIN  = 8'b0100_0000,
        ST_DONE   = 8'b1000_0000
    } state_e;

    typedef struct packed {
        logic [10:0] width;
        logic [10:0] num;
        logic [15:0] gap;
    } desc_t;

    // A freshly reset entry is the smallest legal train: one 2 ns pulse, 1 us gap.
    function automatic desc_t desc_reset_val();
        desc_t d;
        d.width = 11'd1;
        d.num   = 11'd1;
        d.gap   = 16'd1;
        return d;
    endfunction

endpackage

// File: rtl/pulse_desc_table.sv
// Register file of train descriptors: one synchronous write port, one
// combinational read port indexed by the sequencer.
module pulse_desc_table
    import pulse_seq_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  desc_t      wdata_i,
    input  logic [2:0] raddr_i,
    output desc_t      rdata_o
);

    desc_t table_q [NUM_ENTRIES];

    // Descriptor storage; every entry returns to the minimal train on reset.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                table_q[i] <= desc_reset_val();
            end
        end else if (we_i && ({29'd0, waddr_i} < 32'(NUM_ENTRIES))) begin
            table_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range reads return the reset descriptor rather than X.
    always_comb begin
        rdata_o = desc_reset_val();
        if ({29'd0, raddr_i} < 32'(NUM_ENTRIES)) begin
            rdata_o = table_q[raddr_i];
        end else begin
            rdata_o = desc_reset_val();
        end
    end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-train sequencer: walks the descriptor table, hands each train to the
// pulse generator with a settle/start handshake, and repeats the sequence.
module pulse_seq_ctrl
    import pulse_seq_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int START_CYC   = START_CYC_DEF
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [10:0] cfg_width,
    input  logic [10:0] cfg_num,
    input  logic [15:0] cfg_gap,
    input  logic [3:0]  seq_len_i,
    input  logic [7:0]  rep_i,
    input  logic        go_i,
    input  logic        abort_i,
    output logic [10:0] pg_width_o,
    output logic [10:0] pg_num_o,
    output logic [15:0] pg_gap_o,
    output logic        pg_start_o,
    input  logic        pg_done_i,
    output logic        busy_o,
    output logic        seq_done_o,
    output logic [2:0]  entry_idx_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  rep_q, rep_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic [7:0]  rep_eff_q, rep_eff_d;
    desc_t       desc_q, desc_d;
    logic [2:0]  entry_idx_q, entry_idx_d;
    logic        err_q, err_d;
    logic        start_q, busy_q, done_q;
    logic        wr_ok_s, len_ok_s;
    desc_t       wdata_s, rdata_s;

    assign wr_ok_s  = cfg_we && (state_q == ST_IDLE) && (cfg_num != 11'd0) && (cfg_gap != 16'd0);
    assign len_ok_s = (seq_len_i != 4'd0) && ({28'd0, seq_len_i} <= 32'(NUM_ENTRIES));

    always_comb begin
        wdata_s       = '0;
        wdata_s.width = cfg_width;
        wdata_s.num   = cfg_num;
        wdata_s.gap   = cfg_gap;
    end

    pulse_desc_table #(.NUM_ENTRIES(NUM_ENTRIES)) u_table (
        .clk_div (clk_div),
        .rst     (rst),
        .we_i    (wr_ok_s),
        .waddr_i (cfg_addr),
        .wdata_i (wdata_s),
        .raddr_i (idx_q),
        .rdata_o (rdata_s)
    );

    // Next-state logic; pg_* parameters only change in LOAD so they stay stable through WAIT.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        rep_eff_d   = rep_eff_q;
        desc_d      = desc_q;
        entry_idx_d = entry_idx_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (go_i && len_ok_s) begin
                    state_d   = ST_LOAD;
                    idx_d     = 3'd0;
                    rep_d     = 8'd0;
                    len_d     = seq_len_i;
                    rep_eff_d = (rep_i == 8'd0) ? 8'd1 : rep_i;
                    err_d     = 1'b0;
                end else if (go_i) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else begin
                    desc_d      = rdata_s;
                    entry_idx_d = idx_q;
                    cnt_d       = 3'd0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (cnt_q == 3'(SETTLE_CYC - 1)) begin
                    cnt_d   = 3'd0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_START: begin
                if (abort_i) begin
                    state_d = ST_DRAIN;
                end else if (cnt_q == 3'(START_CYC - 1)) begin
                    cnt_d   = 3'd0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (pg_done_i && abort_i) begin
                    state_d = ST_DONE;
                end else if (pg_done_i) begin
                    state_d = ST_NEXT;
                end else if (abort_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if ({1'b0, idx_q} < (len_q - 4'd1)) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_LOAD;
                end else if (rep_q < (rep_eff_q - 8'd1)) begin
                    rep_d   = rep_q + 8'd1;
                    idx_d   = 3'd0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (pg_done_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cfg_we && !wr_ok_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // State and output registers; strobes are decoded from the next state so they are registered.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            rep_q       <= 8'd0;
            cnt_q       <= 3'd0;
            len_q       <= 4'd0;
            rep_eff_q   <= 8'd0;
            desc_q      <= '0;
            entry_idx_q <= 3'd0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            rep_eff_q   <= rep_eff_d;
            desc_q      <= desc_d;
            entry_idx_q <= entry_idx_d;
            err_q       <= err_d;
            start_q     <= (state_d == ST_START);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign pg_width_o  = desc_q.width;
    assign pg_num_o    = desc_q.num;
    assign pg_gap_o    = desc_q.gap;
    assign pg_start_o  = start_q;
    assign busy_o      = busy_q;
    assign seq_done_o  = done_q;
    assign entry_idx_o = entry_idx_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl with a pulse-generator reply model that
// answers each start rise with pg_done_i a fixed number of cycles later.
module tb_pulse_seq_ctrl;

    localparam int REPLY_DLY = 20;

    logic        clk_div = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [10:0] cfg_width;
    logic [10:0] cfg_num;
    logic [15:0] cfg_gap;
    logic [3:0]  seq_len_i;
    logic [7:0]  rep_i;
    logic        go_i;
    logic        abort_i;
    logic [10:0] pg_width_o;
    logic [10:0] pg_num_o;
    logic [15:0] pg_gap_o;
    logic        pg_start_o;
    logic        pg_done_i = 1'b0;
    logic        busy_o;
    logic        seq_done_o;
    logic [2:0]  entry_idx_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int go_cyc = 0;
    int dcnt = 0;
    logic prev_start = 1'b0;
    int n_starts = 0;
    int n_high = 0;
    int n_done = 0;
    int done_cyc = 0;
    int pgdone_cyc = 0;
    logic [2:0]  start_idx [16];
    logic [10:0] start_w   [16];
    logic [10:0] start_n   [16];
    logic [15:0] start_g   [16];
    int          start_cyc [16];

    pulse_seq_ctrl dut (
        .clk_div     (clk_div),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_width   (cfg_width),
        .cfg_num     (cfg_num),
        .cfg_gap     (cfg_gap),
        .seq_len_i   (seq_len_i),
        .rep_i       (rep_i),
        .go_i        (go_i),
        .abort_i     (abort_i),
        .pg_width_o  (pg_width_o),
        .pg_num_o    (pg_num_o),
        .pg_gap_o    (pg_gap_o),
        .pg_start_o  (pg_start_o),
        .pg_done_i   (pg_done_i),
        .busy_o      (busy_o),
        .seq_done_o  (seq_done_o),
        .entry_idx_o (entry_idx_o),
        .err_o       (err_o)
    );

    always #4 clk_div = ~clk_div;

    always @(posedge clk_div) cyc <= cyc + 1;

    // Pulse-generator reply model and start/done monitor.
    always @(negedge clk_div) begin
        pg_done_i = 1'b0;
        if (rst) begin
            dcnt = 0;
        end else if (pg_start_o && !prev_start) begin
            dcnt = REPLY_DLY;
            if (n_starts < 16) begin
                start_idx[n_starts] = entry_idx_o;
                start_w[n_starts]   = pg_width_o;
                start_n[n_starts]   = pg_num_o;
                start_g[n_starts]   = pg_gap_o;
                start_cyc[n_starts] = cyc;
            end
            n_starts++;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                pg_done_i  = 1'b1;
                pgdone_cyc = cyc;
            end
        end
        if (pg_start_o) n_high++;
        if (seq_done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_start = pg_start_o;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [10:0] w, input logic [10:0] n, input logic [15:0] g);
        @(negedge clk_div);
        cfg_we = 1'b1; cfg_addr = a; cfg_width = w; cfg_num = n; cfg_gap = g;
        @(negedge clk_div);
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] len, input logic [7:0] rep, input logic ab);
        @(negedge clk_div);
        seq_len_i = len; rep_i = rep; go_i = 1'b1; abort_i = ab; go_cyc = cyc;
        @(negedge clk_div);
        go_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk_div);
        while (busy_o === 1'b1 && k < budget) begin
            @(negedge clk_div);
            k++;
        end
        check({tag, "_idle_timeout"}, 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_div);
    endtask

    task automatic clear_mon();
        n_starts = 0; n_high = 0; n_done = 0;
    endtask

    initial begin
        int k;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_width = 11'd0; cfg_num = 11'd0;
        cfg_gap = 16'd0; seq_len_i = 4'd0; rep_i = 8'd0; go_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk_div);
        rst = 1'b0;
        @(negedge clk_div);
        check("rst_start", 64'(pg_start_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(seq_done_o), 64'd0);
        check("rst_err",   64'(err_o), 64'd0);
        check("rst_idx",   64'(entry_idx_o), 64'd0);
        check("rst_width", 64'(pg_width_o), 64'd0);
        check("rst_num",   64'(pg_num_o), 64'd0);
        check("rst_gap",   64'(pg_gap_o), 64'd0);

        // Three-entry single pass
        cfg_write(3'd0, 11'd5, 11'd2, 16'd1);
        cfg_write(3'd1, 11'd16, 11'd1, 16'd2);
        cfg_write(3'd2, 11'h7FF, 11'd3, 16'd1);
        clear_mon();
        go(4'd3, 8'd1, 1'b0);
        wait_idle(400, "t1");
        check("t1_starts", 64'(n_starts), 64'd3);
        for (int i = 0; i < 3; i++) check("t1_idx_order", 64'(start_idx[i]), 64'(i));
        check("t1_w0", 64'(start_w[0]), 64'd5);
        check("t1_n0", 64'(start_n[0]), 64'd2);
        check("t1_g1", 64'(start_g[1]), 64'd2);
        check("t1_w2", 64'(start_w[2]), 64'h7FF);
        check("t1_n2", 64'(start_n[2]), 64'd3);
        check("t1_latency", 64'(start_cyc[0] - go_cyc), 64'd6);
        check("t1_start_high_cycles", 64'(n_high), 64'd12);
        check("t1_seq_done", 64'(n_done), 64'd1);

        // Two entries repeated three times
        clear_mon();
        go(4'd2, 8'd3, 1'b0);
        wait_idle(800, "t2");
        check("t2_starts", 64'(n_starts), 64'd6);
        for (int i = 0; i < 6; i++) check("t2_idx_order", 64'(start_idx[i]), 64'(i % 2));
        check("t2_seq_done", 64'(n_done), 64'd1);

        // Abort during WAIT of entry 1
        clear_mon();
        go(4'd3, 8'd1, 1'b0);
        k = 0;
        while (!(n_starts == 2 && pg_start_o == 1'b0) && k < 300) begin
            @(negedge clk_div);
            k++;
        end
        check("t3_reach_wait", 64'(n_starts), 64'd2);
        repeat (2) @(negedge clk_div);
        abort_i = 1'b1;
        @(negedge clk_div);
        abort_i = 1'b0;
        check("t3_drain_busy", 64'(busy_o), 64'd1);
        check("t3_drain_start", 64'(pg_start_o), 64'd0);
        wait_idle(100, "t3");
        check("t3_starts", 64'(n_starts), 64'd2);
        check("t3_seq_done", 64'(n_done), 64'd1);
        check("t3_done_after_pgdone", 64'(done_cyc - pgdone_cyc), 64'd1);
        check("t3_last_idx", 64'(entry_idx_o), 64'd1);

        // Rejected writes
        cfg_write(3'd0, 11'd9, 11'd0, 16'd5);
        check("t4_num0_err", 64'(err_o), 64'd1);
        clear_mon();
        go(4'd1, 8'd1, 1'b0);
        check("t4_go_clears_err", 64'(err_o), 64'd0);
        cfg_write(3'd1, 11'd33, 11'd4, 16'd4);
        check("t4_busy_write_err", 64'(err_o), 64'd1);
        wait_idle(200, "t4a");
        check("t4_entry0_kept", 64'(start_w[0]), 64'd5);
        go(4'd1, 8'd1, 1'b0);
        check("t4_go_clears_err2", 64'(err_o), 64'd0);
        wait_idle(200, "t4b");
        cfg_write(3'd2, 11'd9, 11'd5, 16'd0);
        check("t4_gap0_err", 64'(err_o), 64'd1);
        clear_mon();
        go(4'd3, 8'd1, 1'b0);
        wait_idle(400, "t4c");
        check("t4_entry1_w_kept", 64'(start_w[1]), 64'd16);
        check("t4_entry1_g_kept", 64'(start_g[1]), 64'd2);
        check("t4_entry2_w_kept", 64'(start_w[2]), 64'h7FF);
        check("t4_entry2_n_kept", 64'(start_n[2]), 64'd3);
        check("t4_err_cleared", 64'(err_o), 64'd0);

        // Illegal lengths and go+abort together
        go(4'd0, 8'd1, 1'b0);
        check("t5_len0_busy", 64'(busy_o), 64'd0);
        check("t5_len0_err", 64'(err_o), 64'd1);
        clear_mon();
        go(4'd1, 8'd0, 1'b1);
        check("t5_go_abort_busy", 64'(busy_o), 64'd1);
        check("t5_go_abort_err", 64'(err_o), 64'd0);
        wait_idle(200, "t5");
        check("t5_go_abort_starts", 64'(n_starts), 64'd1);
        check("t5_go_abort_done", 64'(n_done), 64'd1);
        go(4'd9, 8'd1, 1'b0);
        check("t5_len9_busy", 64'(busy_o), 64'd0);
        check("t5_len9_err", 64'(err_o), 64'd1);

        // Reset while in START
        clear_mon();
        go(4'd3, 8'd1, 1'b0);
        k = 0;
        while (pg_start_o !== 1'b1 && k < 20) begin
            @(negedge clk_div);
            k++;
        end
        check("t6_reach_start", 64'(pg_start_o), 64'd1);
        rst = 1'b1;
        @(negedge clk_div);
        rst = 1'b0;
        check("t6_start", 64'(pg_start_o), 64'd0);
        check("t6_busy",  64'(busy_o), 64'd0);
        check("t6_done",  64'(seq_done_o), 64'd0);
        check("t6_err",   64'(err_o), 64'd0);
        check("t6_idx",   64'(entry_idx_o), 64'd0);
        check("t6_pg",    64'({pg_width_o, pg_num_o, pg_gap_o}), 64'd0);
        repeat (30) @(negedge clk_div);
        check("t6_stays_idle", 64'(busy_o), 64'd0);
        clear_mon();
        go(4'd3, 8'd1, 1'b0);
        wait_idle(400, "t6");
        check("t6_starts", 64'(n_starts), 64'd3);
        check("t6_tbl_w0", 64'(start_w[0]), 64'd1);
        check("t6_tbl_w2", 64'(start_w[2]), 64'd1);
        check("t6_tbl_n2", 64'(start_n[2]), 64'd1);
        check("t6_tbl_g2", 64'(start_g[2]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
